// File: rtl/sum_serial_nb.sv
// Multi-cycle adder/subtractor: DIGIT bits per cycle through a registered carry,
// start/busy/done handshake, registered S/Cout/overflow/zero.
module sum_serial_nb #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NSL = WIDTH / DIGIT;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("sum_serial_nb: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r, b_r, acc;
  logic [CW-1:0]    cnt;
  logic             carry, cmsb;
  logic [DIGIT:0]   slice;
  logic             slice_cmsb;
  logic [WIDTH-1:0] acc_nxt;

  always_comb begin
    slice      = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // Carry into the slice's top bit recovered from its sum bit and operands.
    slice_cmsb = slice[DIGIT-1] ^ a_r[DIGIT-1] ^ b_r[DIGIT-1];
    acc_nxt    = WIDTH'({slice[DIGIT-1:0], acc} >> DIGIT);
  end

  // busy/done are registered views of the state, so they trail it by one cycle;
  // acceptance waits for busy to drop so a start can never overlap the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      cmsb     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      S        <= '0;
      Cout     <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (start && !busy) begin
            a_r   <= A;
            b_r   <= sub ? ~B : B;
            carry <= sub ? ~Ci : Ci;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt;
          carry <= slice[DIGIT];
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            cmsb  <= slice_cmsb;
            state <= DONE;
          end
        end
        DONE: begin
          S        <= acc;
          Cout     <= carry;
          overflow <= cmsb ^ carry;
          zero     <= (acc == '0);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
